cfg_chain_loader: RTL and testbench

- Parametrised successor to the single-bit tile configuration loader for the CGRA configuration chain.
- Accepts a multi-lane serial stream of addressed frames. Each frame carries a tile ID, a start address, a word count and payload words.
- Writes payload into the local tile's configuration memory when the ID matches, or when the ID is the broadcast ID.
- Re-registers the stream unchanged to the next tile in the daisy chain.

---
 rtl/cfg_chain_loader.sv | 200 ++++++++++++++++++++
 tb/tb_cfg_chain_loader.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_chain_loader.sv
// cfg_chain_loader: addressed multi-lane config frame loader and chain repeater.
// Optional trailing XOR checksum of payload words: define CFG_CHKSUM_EN.
module cfg_chain_loader #(
  parameter int NUM_TILES = 4,
  parameter int TILE_ID   = 0,
  parameter int LANES     = 1,
  parameter int WORD_W    = 32,
  parameter int DEPTH     = 128,
  parameter int ID_W      = 8,
  parameter int CNT_W     = 8,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LANES-1:0]  data_in,
  input  logic              data_valid,
  output logic [LANES-1:0]  data_out,
  output logic              data_valid_out,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              done,
  output logic              configured,
  output logic              error
);

  // Address field on the wire is ADDR_W rounded up to whole bytes.
  localparam int AFLD_W = ((ADDR_W + 7) / 8) * 8;
  localparam int M1_W   = (WORD_W > ID_W) ? WORD_W : ID_W;
  localparam int M2_W   = (M1_W > CNT_W) ? M1_W : CNT_W;
  localparam int SR_W   = (M2_W > AFLD_W) ? M2_W : AFLD_W;
  localparam int BC_W   = $clog2(SR_W / LANES + 1);

  localparam logic [ID_W-1:0] BCAST = '1;
  localparam logic [ID_W-1:0] MY_ID = ID_W'(TILE_ID);
  localparam bit              ID_OK = (TILE_ID < NUM_TILES);

  localparam logic [2:0] S_ID   = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_CNT  = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
`ifdef CFG_CHKSUM_EN
  localparam logic [2:0] S_CHK  = 3'd4;
`endif

  logic [2:0]            state_q, state_d;
  logic [BC_W-1:0]       bc_q, bc_d;
  logic [SR_W-LANES-1:0] sr_q, sr_d;
  logic [SR_W-1:0]       shifted;
  logic [BC_W-1:0]       fbeats;
  logic                  last;
  logic                  match_q, match_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [CNT_W:0]        left_q, left_d;
  logic [LANES-1:0]      dout_q;
  logic                  dvo_q;
  logic                  we_q, we_d;
  logic [ADDR_W-1:0]     waddr_q, waddr_d;
  logic [WORD_W-1:0]     wdata_q, wdata_d;
  logic                  done_q, done_d;
  logic                  cfg_q, cfg_d;
`ifdef CFG_CHKSUM_EN
  logic [WORD_W-1:0]     x_q, x_d;
  logic                  err_q, err_d;
`endif

  assign shifted = {sr_q, data_in};

  always_comb begin
    fbeats = BC_W'(WORD_W / LANES);
    unique case (state_q)
      S_ID:    fbeats = BC_W'(ID_W / LANES);
      S_ADDR:  fbeats = BC_W'(AFLD_W / LANES);
      S_CNT:   fbeats = BC_W'(CNT_W / LANES);
      default: fbeats = BC_W'(WORD_W / LANES);
    endcase
  end

  assign last = data_valid && (bc_q == fbeats - 1'b1);

  always_comb begin
    state_d = state_q;
    bc_d    = bc_q;
    sr_d    = sr_q;
    match_d = match_q;
    addr_d  = addr_q;
    left_d  = left_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
`ifdef CFG_CHKSUM_EN
    x_d     = x_q;
    err_d   = err_q;
`endif
    if (data_valid) begin
      sr_d = shifted[SR_W-LANES-1:0];
      bc_d = last ? '0 : bc_q + 1'b1;
    end
    if (last) begin
      unique case (state_q)
        S_ID: begin
          match_d = (ID_OK && shifted[ID_W-1:0] == MY_ID) ||
                    (shifted[ID_W-1:0] == BCAST);
          state_d = S_ADDR;
        end
        S_ADDR: begin
          addr_d  = shifted[ADDR_W-1:0];
          state_d = S_CNT;
        end
        S_CNT: begin
          left_d  = {1'b0, shifted[CNT_W-1:0]} + 1'b1;
          state_d = S_DATA;
`ifdef CFG_CHKSUM_EN
          x_d     = '0;
`endif
        end
        S_DATA: begin
          we_d    = match_q;
          waddr_d = addr_q;
          wdata_d = shifted[WORD_W-1:0];
          addr_d  = (addr_q == ADDR_W'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
          left_d  = left_q - 1'b1;
`ifdef CFG_CHKSUM_EN
          x_d     = x_q ^ shifted[WORD_W-1:0];
          if (left_q == (CNT_W+1)'(1)) state_d = S_CHK;
`else
          if (left_q == (CNT_W+1)'(1)) begin
            done_d  = match_q;
            state_d = S_ID;
          end
`endif
        end
`ifdef CFG_CHKSUM_EN
        S_CHK: begin
          done_d  = match_q;
          if (match_q && shifted[WORD_W-1:0] != x_q) err_d = 1'b1;
          state_d = S_ID;
        end
`endif
        default: state_d = S_ID;
      endcase
    end
    cfg_d = cfg_q | done_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_ID;
      bc_q    <= '0;
      sr_q    <= '0;
      match_q <= 1'b0;
      addr_q  <= '0;
      left_q  <= '0;
      dout_q  <= '0;
      dvo_q   <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      cfg_q   <= 1'b0;
`ifdef CFG_CHKSUM_EN
      x_q     <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      bc_q    <= bc_d;
      sr_q    <= sr_d;
      match_q <= match_d;
      addr_q  <= addr_d;
      left_q  <= left_d;
      dout_q  <= data_in;
      dvo_q   <= data_valid;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      cfg_q   <= cfg_d;
`ifdef CFG_CHKSUM_EN
      x_q     <= x_d;
      err_q   <= err_d;
`endif
    end
  end

  assign data_out       = dout_q;
  assign data_valid_out = dvo_q;
  assign mem_we         = we_q;
  assign mem_addr       = waddr_q;
  assign mem_wdata      = wdata_q;
  assign done           = done_q;
  assign configured     = cfg_q;
`ifdef CFG_CHKSUM_EN
  assign error          = err_q;
`else
  assign error          = 1'b0;
`endif

endmodule

// File: tb/tb_cfg_chain_loader.sv
// tb_cfg_chain_loader: scoreboard bench, one LANES=1 and one LANES=4 instance.
// Writes are predicted as beats are sent and checked as mem_we appears.
module tb_cfg_chain_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [0:0]  d1_in = '0;
  logic        d1_v  = 1'b0;
  logic [0:0]  o1_out;
  logic        o1_vo, o1_we, o1_done, o1_cfg, o1_err;
  logic [6:0]  o1_addr;
  logic [31:0] o1_wdata;

  logic [3:0]  d4_in = '0;
  logic        d4_v  = 1'b0;
  logic [3:0]  o4_out;
  logic        o4_vo, o4_we, o4_done, o4_cfg, o4_err;
  logic [6:0]  o4_addr;
  logic [31:0] o4_wdata;

  cfg_chain_loader #(.LANES(1)) u1 (
    .clk(clk), .rst(rst), .data_in(d1_in), .data_valid(d1_v),
    .data_out(o1_out), .data_valid_out(o1_vo), .mem_we(o1_we),
    .mem_addr(o1_addr), .mem_wdata(o1_wdata), .done(o1_done),
    .configured(o1_cfg), .error(o1_err)
  );

  cfg_chain_loader #(.LANES(4)) u4 (
    .clk(clk), .rst(rst), .data_in(d4_in), .data_valid(d4_v),
    .data_out(o4_out), .data_valid_out(o4_vo), .mem_we(o4_we),
    .mem_addr(o4_addr), .mem_wdata(o4_wdata), .done(o4_done),
    .configured(o4_cfg), .error(o4_err)
  );

  typedef struct {
    int          cyc;
    logic [6:0]  addr;
    logic [31:0] data;
    logic        dn;
  } exp_t;

  exp_t        q1[$], q4[$];
  int          wc1[$], wc4[$];
  int          tests = 0, fails = 0, cyc = 0;
  int          dn1 = 0, dn4 = 0, dc1 = 0;
  logic [31:0] pl[$];
  logic [0:0]  p1 = '0;
  logic        p1v = 1'b0;
  logic [3:0]  p4 = '0;
  logic        p4v = 1'b0;

  // Reference for the repeater path: one-cycle delay, cleared by reset.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    p1  <= rst ? '0 : d1_in;
    p1v <= rst ? 1'b0 : d1_v;
    p4  <= rst ? '0 : d4_in;
    p4v <= rst ? 1'b0 : d4_v;
  end

  task automatic mon();
    exp_t e;
    @(negedge clk);
    tests++;
    if (o1_out !== p1 || o1_vo !== p1v) begin
      fails++;
      $display("FAIL passthru1 cyc=%0d got %b/%b exp %b/%b",
               cyc, o1_out, o1_vo, p1, p1v);
    end
    tests++;
    if (o4_out !== p4 || o4_vo !== p4v) begin
      fails++;
      $display("FAIL passthru4 cyc=%0d got %h/%b exp %h/%b",
               cyc, o4_out, o4_vo, p4, p4v);
    end
    if (o1_we === 1'b1) begin
      wc1.push_back(cyc);
      tests++;
      if (q1.size() == 0) begin
        fails++;
        $display("FAIL write1 unexpected cyc=%0d addr=%0d data=%h",
                 cyc, o1_addr, o1_wdata);
      end else begin
        e = q1.pop_front();
        if (cyc !== e.cyc || o1_addr !== e.addr ||
            o1_wdata !== e.data || o1_done !== e.dn) begin
          fails++;
          $display("FAIL write1 got c%0d a%0d d%h dn%b exp c%0d a%0d d%h dn%b",
                   cyc, o1_addr, o1_wdata, o1_done,
                   e.cyc, e.addr, e.data, e.dn);
        end
      end
    end
    if (o4_we === 1'b1) begin
      wc4.push_back(cyc);
      tests++;
      if (q4.size() == 0) begin
        fails++;
        $display("FAIL write4 unexpected cyc=%0d addr=%0d data=%h",
                 cyc, o4_addr, o4_wdata);
      end else begin
        e = q4.pop_front();
        if (cyc !== e.cyc || o4_addr !== e.addr ||
            o4_wdata !== e.data || o4_done !== e.dn) begin
          fails++;
          $display("FAIL write4 got c%0d a%0d d%h dn%b exp c%0d a%0d d%h dn%b",
                   cyc, o4_addr, o4_wdata, o4_done,
                   e.cyc, e.addr, e.data, e.dn);
        end
      end
    end
    if (o1_done === 1'b1) begin
      dn1++;
      dc1 = cyc;
    end
    if (o4_done === 1'b1) dn4++;
  endtask

  task automatic idle(input int lanes, input int n);
    repeat (n) begin
      @(negedge clk);
      if (lanes == 1) begin
        d1_v  = 1'b0;
        d1_in = 1'($urandom);
      end else begin
        d4_v  = 1'b0;
        d4_in = 4'($urandom);
      end
      @(posedge clk);
    end
  endtask

  // Sends pl as one frame; cut>0 stops after that many beats.
  task automatic send_frame(input int lanes, input logic [7:0] id,
                            input logic [7:0] addr, input logic [7:0] cnt,
                            input bit chk_ovr, input logic [31:0] chk_val,
                            input int gap_at, input int gap_len,
                            input int cut, output int first_c,
                            output int last_c);
    logic        b[$];
    logic [31:0] x;
    logic [6:0]  a;
    bit          m;
    int          nb, eb, w;
    exp_t        e;
    x = '0;
    foreach (pl[i]) x ^= pl[i];
    if (chk_ovr) x = chk_val;
    for (int i = 7; i >= 0; i--) b.push_back(id[i]);
    for (int i = 7; i >= 0; i--) b.push_back(addr[i]);
    for (int i = 7; i >= 0; i--) b.push_back(cnt[i]);
    foreach (pl[k]) for (int i = 31; i >= 0; i--) b.push_back(pl[k][i]);
`ifdef CFG_CHKSUM_EN
    for (int i = 31; i >= 0; i--) b.push_back(x[i]);
`endif
    m  = (id == 8'h00) || (id == 8'hFF);
    a  = addr[6:0];
    nb = b.size() / lanes;
    if (cut > 0) nb = cut;
    first_c = 0;
    last_c  = 0;
    for (int k = 0; k < nb; k++) begin
      if (k == gap_at) idle(lanes, gap_len);
      @(negedge clk);
      if (lanes == 1) begin
        d1_in[0] = b[k];
        d1_v     = 1'b1;
      end else begin
        for (int j = 0; j < 4; j++) d4_in[3-j] = b[k*4+j];
        d4_v = 1'b1;
      end
      @(posedge clk);
      #1;
      if (k == 0) first_c = cyc;
      last_c = cyc;
      eb = (k + 1) * lanes;
      if (eb > 24 && (eb - 24) % 32 == 0 && (eb - 24) / 32 <= pl.size()) begin
        w = (eb - 24) / 32 - 1;
        if (m) begin
          e.cyc  = cyc;
          e.addr = a;
          e.data = pl[w];
`ifdef CFG_CHKSUM_EN
          e.dn   = 1'b0;
`else
          e.dn   = (w == pl.size() - 1);
`endif
          if (lanes == 1) q1.push_back(e);
          else q4.push_back(e);
        end
        a = a + 7'd1;
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    tests++;
    if ({o1_out, o1_vo, o1_we, o1_addr, o1_wdata,
         o1_done, o1_cfg, o1_err} !== '0) begin
      fails++;
      $display("FAIL %s_dut1 got we%b a%0d d%h dn%b cfg%b err%b vo%b exp all 0",
               tag, o1_we, o1_addr, o1_wdata, o1_done, o1_cfg, o1_err, o1_vo);
    end
    tests++;
    if ({o4_out, o4_vo, o4_we, o4_addr, o4_wdata,
         o4_done, o4_cfg, o4_err} !== '0) begin
      fails++;
      $display("FAIL %s_dut4 got we%b a%0d d%h dn%b cfg%b err%b vo%b exp all 0",
               tag, o4_we, o4_addr, o4_wdata, o4_done, o4_cfg, o4_err, o4_vo);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int f, l, d0;
    pl = '{32'hDEADBEEF, 32'h12345678};
    wc1.delete();
    d0 = dn1;
    send_frame(1, 8'd0, 8'd5, 8'd1, 1'b0, '0, -1, 0, 0, f, l);
    idle(1, 3);
    tests++;
    if (wc1.size() != 2 || wc1[0] - f != 55 || wc1[1] - wc1[0] != 32) begin
      fails++;
      $display("FAIL basic_timing got n=%0d w0=%0d dw=%0d exp n=2 w0=55 dw=32",
               wc1.size(), wc1.size() > 0 ? wc1[0] - f : -1,
               wc1.size() > 1 ? wc1[1] - wc1[0] : -1);
    end
    tests++;
    if (dn1 - d0 != 1 || o1_cfg !== 1'b1) begin
      fails++;
      $display("FAIL basic_done got done=%0d cfg=%b exp 1/1", dn1 - d0, o1_cfg);
    end
`ifdef CFG_CHKSUM_EN
    tests++;
    if (dc1 != l) begin
      fails++;
      $display("FAIL basic_done_cyc got %0d exp %0d", dc1, l);
    end
`endif
  endtask

  task automatic test_ignore();
    int f, l, d0;
    logic [7:0] ids[3];
    ids = '{8'd2, 8'd5, 8'hFF};
    pl = '{32'hDEADBEEF, 32'h12345678};
    for (int i = 0; i < 3; i++) begin
      wc1.delete();
      d0 = dn1;
      send_frame(1, ids[i], 8'd5, 8'd1, 1'b0, '0, -1, 0, 0, f, l);
      idle(1, 3);
      tests++;
      if (wc1.size() != ((ids[i] == 8'hFF) ? 2 : 0) ||
          dn1 - d0 != ((ids[i] == 8'hFF) ? 1 : 0)) begin
        fails++;
        $display("FAIL ignore_id%0d got writes=%0d done=%0d",
                 ids[i], wc1.size(), dn1 - d0);
      end
    end
  endtask

  task automatic test_lanes4();
    int f, l, d0;
    pl = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    wc4.delete();
    d0 = dn4;
    send_frame(4, 8'd0, 8'd126, 8'd3, 1'b0, '0, -1, 0, 0, f, l);
    idle(4, 3);
    tests++;
    if (wc4.size() != 4 || wc4[0] - f != 13 || wc4[1] - wc4[0] != 8 ||
        wc4[2] - wc4[1] != 8 || wc4[3] - wc4[2] != 8) begin
      fails++;
      $display("FAIL lanes4_timing got n=%0d exp n=4 first=13 step=8",
               wc4.size());
    end
    tests++;
    if (dn4 - d0 != 1 || o4_cfg !== 1'b1) begin
      fails++;
      $display("FAIL lanes4_done got done=%0d cfg=%b exp 1/1", dn4 - d0, o4_cfg);
    end
  endtask

  task automatic test_gap();
    int f, l;
    pl = '{32'hDEADBEEF, 32'h12345678};
    wc1.delete();
    send_frame(1, 8'd0, 8'd5, 8'd1, 1'b0, '0, 40, 7, 0, f, l);
    idle(1, 3);
    tests++;
    if (wc1.size() != 2 || wc1[0] - f != 62 || wc1[1] - wc1[0] != 32) begin
      fails++;
      $display("FAIL gap_timing got n=%0d w0=%0d exp n=2 w0=62 dw=32",
               wc1.size(), wc1.size() > 0 ? wc1[0] - f : -1);
    end
  endtask

  task automatic test_back_to_back();
    int f, l, d0;
    wc1.delete();
    d0 = dn1;
    pl = '{32'h0BADF00D};
    send_frame(1, 8'd0, 8'd10, 8'd0, 1'b0, '0, -1, 0, 0, f, l);
    pl = '{32'h600DCAFE, 32'h5A5A0001};
    send_frame(1, 8'hFF, 8'd127, 8'd1, 1'b0, '0, -1, 0, 0, f, l);
    idle(1, 3);
    tests++;
    if (wc1.size() != 3 || dn1 - d0 != 2 || q1.size() != 0) begin
      fails++;
      $display("FAIL b2b got writes=%0d done=%0d pending=%0d exp 3/2/0",
               wc1.size(), dn1 - d0, q1.size());
    end
  endtask

  task automatic test_rst_mid();
    int f, l, d0;
    pl = '{32'hCAFEBABE, 32'h87654321};
    send_frame(1, 8'd0, 8'd3, 8'd1, 1'b0, '0, -1, 0, 40, f, l);
    @(negedge clk);
    rst  = 1'b1;
    d1_v = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_idle_outputs("rst_mid");
    rst = 1'b0;
    wc1.delete();
    d0 = dn1;
    pl = '{32'hA5A5A5A5};
    send_frame(1, 8'd0, 8'd0, 8'd0, 1'b0, '0, -1, 0, 0, f, l);
    idle(1, 3);
    tests++;
    if (wc1.size() != 1 || dn1 - d0 != 1 || o1_cfg !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid_frame got writes=%0d done=%0d cfg=%b exp 1/1/1",
               wc1.size(), dn1 - d0, o1_cfg);
    end
  endtask

`ifdef CFG_CHKSUM_EN
  task automatic test_chksum();
    int f, l, d0;
    pl = '{32'h0F0F0F0F, 32'hF0F0F0F0};
    d0 = dn1;
    send_frame(1, 8'd0, 8'd40, 8'd1, 1'b1, 32'hFFFFFFFF, -1, 0, 0, f, l);
    idle(1, 3);
    tests++;
    if (o1_err !== 1'b0 || dn1 - d0 != 1 || dc1 != l) begin
      fails++;
      $display("FAIL chk_good got err=%b done=%0d dcyc=%0d exp 0/1/%0d",
               o1_err, dn1 - d0, dc1, l);
    end
    d0 = dn1;
    send_frame(1, 8'd0, 8'd40, 8'd1, 1'b1, 32'h00000000, -1, 0, 0, f, l);
    idle(1, 3);
    tests++;
    if (o1_err !== 1'b1 || dn1 - d0 != 1 || dc1 != l) begin
      fails++;
      $display("FAIL chk_bad got err=%b done=%0d dcyc=%0d exp 1/1/%0d",
               o1_err, dn1 - d0, dc1, l);
    end
  endtask
`else
  task automatic test_no_err();
    tests++;
    if (o1_err !== 1'b0 || o4_err !== 1'b0) begin
      fails++;
      $display("FAIL no_err got %b/%b exp 0/0", o1_err, o4_err);
    end
  endtask
`endif

  initial begin
    fork
      forever mon();
    join_none
    test_reset();
    test_basic();
    test_ignore();
    test_lanes4();
    test_gap();
    test_back_to_back();
    test_rst_mid();
`ifdef CFG_CHKSUM_EN
    test_chksum();
`else
    test_no_err();
`endif
    tests++;
    if (q1.size() != 0 || q4.size() != 0) begin
      fails++;
      $display("FAIL pending_writes got %0d/%0d exp 0/0", q1.size(), q4.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
